// File: rtl/mul_sequencer_if.sv
// Handshake and operand/result bundle for the shift-add multiply sequencer.
interface mul_sequencer_if #(
  parameter int WORD_WIDTH = 8
);
  logic                      start_i;
  logic                      abort_i;
  logic [WORD_WIDTH-1:0]     a_i;
  logic [WORD_WIDTH-1:0]     b_i;
  logic                      ready_o;
  logic                      done_o;
  logic [2*WORD_WIDTH-1:0]   product_o;

  modport master (
    output start_i, abort_i, a_i, b_i,
    input  ready_o, done_o, product_o
  );

  modport slave (
    input  start_i, abort_i, a_i, b_i,
    output ready_o, done_o, product_o
  );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add unsigned multiplier: one partial product per RUN cycle,
// fixed W-cycle run, result held in product_o until the next completion.
module mul_sequencer #(
  parameter int WORD_WIDTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mul_sequencer_if.slave bus
);
  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mult;
  logic [W-1:0]    acc;
  logic            carry;
  logic [CW-1:0]   count;
  logic [2*W-1:0]  product;

  logic [W:0]      sum;
  logic [W-1:0]    acc_shift;
  logic [W-1:0]    mult_shift;
  logic            last_edge;

  // One add-and-shift step; the low bit of the sum falls into the multiplier.
  always_comb begin
    sum        = {carry, acc} + (mult[0] ? {1'b0, mcand} : '0);
    acc_shift  = sum[W:1];
    mult_shift = {sum[0], mult[W-1:1]};
    last_edge  = (count == LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start_i) state_next = RUN;
      RUN: begin
        if (bus.abort_i)     state_next = IDLE;
        else if (last_edge)  state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Abort freezes the datapath; a fresh accept reloads everything anyway.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand   <= '0;
      mult    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            mcand <= bus.a_i;
            mult  <= bus.b_i;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
          end
        end
        RUN: begin
          if (!bus.abort_i) begin
            acc   <= acc_shift;
            mult  <= mult_shift;
            carry <= 1'b0;
            count <= count + CW'(1);
            if (last_edge) product <= {acc_shift, mult_shift};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o   = (state == IDLE);
  assign bus.done_o    = (state == DONE);
  assign bus.product_o = product;
endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed W=8 scenarios plus back-to-back random
// traffic on a W=8 and a W=16 instance, all checked against a timeline model.
module tb_mul_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        drv_start [2];
  logic        drv_abort [2];
  logic [31:0] drv_a     [2];
  logic [31:0] drv_b     [2];

  logic        dut_ready [2];
  logic        dut_done  [2];
  logic [31:0] dut_prod  [2];
  logic        exp_ready [2];
  logic        exp_done  [2];
  logic [31:0] exp_prod  [2];

  int checks = 0;
  int errors = 0;
  bit rand_mode = 1'b0;
  int ops       [2];
  int last_done [2];
  int lo_cnt    = 0;
  int done_cnt  = 0;
  int done_cyc  = 0;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int W = (g == 0) ? 8 : 16;

    mul_sequencer_if #(.WORD_WIDTH(W)) bus ();
    mul_sequencer #(.WORD_WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    assign bus.start_i = drv_start[g];
    assign bus.abort_i = drv_abort[g];
    assign bus.a_i     = drv_a[g][W-1:0];
    assign bus.b_i     = drv_b[g][W-1:0];
    assign dut_ready[g] = bus.ready_o;
    assign dut_done[g]  = bus.done_o;
    assign dut_prod[g]  = 32'(bus.product_o);

    // Model: an accepted start books a product and W busy edges, then one done cycle.
    int             left;
    logic           fin;
    logic [2*W-1:0] pend;
    logic [2*W-1:0] prod;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        left <= 0;
        fin  <= 1'b0;
        pend <= '0;
        prod <= '0;
      end else if (fin) begin
        fin <= 1'b0;
      end else if (left == 0) begin
        if (drv_start[g]) begin
          pend <= (2*W)'(drv_a[g][W-1:0]) * (2*W)'(drv_b[g][W-1:0]);
          left <= W;
        end
      end else if (drv_abort[g]) begin
        left <= 0;
      end else begin
        left <= left - 1;
        if (left == 1) begin
          prod <= pend;
          fin  <= 1'b1;
        end
      end
    end

    assign exp_ready[g] = (left == 0) && !fin;
    assign exp_done[g]  = fin;
    assign exp_prod[g]  = 32'(prod);
  end

  function automatic int wid(input int g);
    return (g == 0) ? 8 : 16;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit start, input bit abort, input logic [31:0] a, input logic [31:0] b);
    drv_start[0] = start;
    drv_abort[0] = abort;
    drv_a[0]     = a;
    drv_b[0]     = b;
  endtask

  // Every negedge: compare both lanes to the model and update lane-0 monitors.
  task automatic tick();
    @(negedge clk);
    if (!dut_ready[0]) lo_cnt++;
    if (dut_done[0] === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("ready_w%0d", wid(g)),   32'(dut_ready[g]), 32'(exp_ready[g]));
      checkOutput($sformatf("done_w%0d", wid(g)),    32'(dut_done[g]),  32'(exp_done[g]));
      checkOutput($sformatf("product_w%0d", wid(g)), dut_prod[g],       exp_prod[g]);
      if (rand_mode && dut_done[g] === 1'b1) begin
        if (last_done[g] >= 0)
          checkOutput($sformatf("spacing_w%0d", wid(g)), 32'(cyc - last_done[g]), 32'(wid(g) + 2));
        last_done[g] = cyc;
        ops[g]++;
      end
    end
  endtask

  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input bit with_abort,
                       input logic [31:0] exp, input string name);
    int e0;
    tick();
    lo_cnt   = 0;
    done_cnt = 0;
    applyStimulus(1'b1, with_abort, a, b);
    e0 = cyc + 1;
    tick();
    applyStimulus(1'b0, 1'b0, $urandom, $urandom);
    for (int n = 0; n < 40 && done_cnt == 0; n++) tick();
    repeat (3) tick();
    checkOutput({name, "_product"}, dut_prod[0], exp);
    checkOutput({name, "_dones"},   32'(done_cnt), 32'd1);
    checkOutput({name, "_latency"}, 32'(done_cyc - e0), 32'd8);
    checkOutput({name, "_busy"},    32'(lo_cnt), 32'd9);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      drv_start[g] = 1'b0;
      drv_abort[g] = 1'b0;
      drv_a[g]     = '0;
      drv_b[g]     = '0;
      ops[g]       = 0;
      last_done[g] = -1;
    end
    #1 rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_ready",   32'(dut_ready[0]), 32'd1);
    checkOutput("rst_done",    32'(dut_done[0]),  32'd0);
    checkOutput("rst_product", dut_prod[0],       32'd0);
    rst = 1'b0;

    runOp(32'd13,  32'd11,  1'b0, 32'h008F, "mul_13x11");
    runOp(32'd255, 32'd255, 1'b0, 32'hFE01, "mul_255x255");
    runOp(32'd0,   32'd200, 1'b0, 32'h0000, "mul_0x200");

    // A start arriving mid-run must be dropped, not queued.
    tick();
    lo_cnt   = 0;
    done_cnt = 0;
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd5);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    for (int n = 0; n < 20 && done_cnt == 0; n++) tick();
    repeat (6) tick();
    checkOutput("ignore_product", dut_prod[0],       32'h000F);
    checkOutput("ignore_dones",   32'(done_cnt),     32'd1);
    checkOutput("ignore_idle",    32'(dut_ready[0]), 32'd1);

    // Abort after E3 returns to IDLE at E4 and leaves the old product.
    tick();
    done_cnt = 0;
    applyStimulus(1'b1, 1'b0, 32'd7, 32'd7);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 32'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("abort_idle_e4", 32'(dut_ready[0]), 32'd1);
    repeat (12) tick();
    checkOutput("abort_dones",   32'(done_cnt), 32'd0);
    checkOutput("abort_product", dut_prod[0],   32'h000F);

    runOp(32'd6, 32'd7, 1'b1, 32'd42, "start_beats_abort");

    // Asynchronous reset in the middle of a run.
    tick();
    applyStimulus(1'b1, 1'b0, 32'd7, 32'd9);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_ready",   32'(dut_ready[0]), 32'd1);
    checkOutput("async_rst_done",    32'(dut_done[0]),  32'd0);
    checkOutput("async_rst_product", dut_prod[0],       32'd0);
    tick();
    tick();
    rst = 1'b0;
    done_cnt = 0;
    repeat (15) tick();
    checkOutput("post_rst_dones",   32'(done_cnt), 32'd0);
    checkOutput("post_rst_product", dut_prod[0],   32'd0);

    // Start held high with fresh random operands every cycle on both widths.
    rand_mode = 1'b1;
    for (int n = 0; n < 30000 && (ops[0] < 1000 || ops[1] < 1000); n++) begin
      for (int g = 0; g < 2; g++) begin
        drv_start[g] = 1'b1;
        drv_abort[g] = 1'b0;
        drv_a[g]     = $urandom;
        drv_b[g]     = $urandom;
      end
      tick();
    end
    checkOutput("rand_ops_w8",  32'(ops[0] >= 1000), 32'd1);
    checkOutput("rand_ops_w16", 32'(ops[1] >= 1000), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
